// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the two register-file write ports between ALU lanes A/B and the
// load unit. Loads that find no free port wait in a small FIFO. WAW ordering is kept by killing older loads.
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int LQ_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        a_valid,
  input  logic [ADDR_WIDTH-1:0]       a_rd,
  input  logic [DATA_WIDTH-1:0]       a_data,
  input  logic                        b_valid,
  input  logic [ADDR_WIDTH-1:0]       b_rd,
  input  logic [DATA_WIDTH-1:0]       b_data,
  input  logic                        ld_valid,
  input  logic [ADDR_WIDTH-1:0]       ld_rd,
  input  logic [DATA_WIDTH-1:0]       ld_data,
  output logic                        ld_ready,
  output logic                        we_a,
  output logic [ADDR_WIDTH-1:0]       wa_a,
  output logic [DATA_WIDTH-1:0]       wd_a,
  output logic                        we_b,
  output logic [ADDR_WIDTH-1:0]       wa_b,
  output logic [DATA_WIDTH-1:0]       wd_b,
  output logic [2**ADDR_WIDTH-1:0]    busy,
  output logic [$clog2(LQ_DEPTH):0]   lq_count
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] lq_rd   [LQ_DEPTH];
  logic [DATA_WIDTH-1:0] lq_data [LQ_DEPTH];
  logic [LQ_DEPTH-1:0]   lq_dead;
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count;

  logic a_go, b_go, slot, lq_empty, head_kill, pop;
  logic ld_acc, ld_kill, bypass, push, load_wr;
  logic [ADDR_WIDTH-1:0] load_rd;
  logic [DATA_WIDTH-1:0] load_data;

  // Lane A loses to lane B (the younger result) when both target the same register.
  assign a_go     = a_valid && (a_rd != '0) && !(b_valid && (b_rd == a_rd));
  assign b_go     = b_valid && (b_rd != '0);
  assign slot     = !a_go || !b_go;
  assign lq_empty = (count == '0);

  // A head matching a same-cycle ALU write is treated as dead so both ports never target one register.
  assign head_kill = lq_dead[head] || (a_go && (lq_rd[head] == a_rd)) ||
                     (b_go && (lq_rd[head] == b_rd));
  assign pop       = !lq_empty && slot;

  // Load handshake: a load transfers on a cycle where ld_valid && ld_ready; the producer holds it otherwise.
  assign ld_ready = rst_n && ((count < CW'(LQ_DEPTH)) || pop);
  assign ld_acc   = ld_valid && ld_ready;
  assign ld_kill  = (ld_rd == '0) || (a_go && (ld_rd == a_rd)) || (b_go && (ld_rd == b_rd));
  assign bypass   = ld_acc && !ld_kill && lq_empty && slot;
  assign push     = ld_acc && !ld_kill && !bypass;

  assign load_wr   = (pop && !head_kill) || bypass;
  assign load_rd   = pop ? lq_rd[head]   : ld_rd;
  assign load_data = pop ? lq_data[head] : ld_data;

  assign lq_count = count;

  always_comb begin
    busy = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if ((CW'(i) < count) && !lq_dead[head + PW'(i)])
        busy[lq_rd[head + PW'(i)]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd[tail]   <= ld_rd;
      lq_data[tail] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      lq_dead <= '0;
      we_a    <= 1'b0;
      wa_a    <= '0;
      wd_a    <= '0;
      we_b    <= 1'b0;
      wa_b    <= '0;
      wd_b    <= '0;
    end else begin
      // The load takes port A when lane A is idle, otherwise port B (slot guarantees B is free).
      we_a <= a_go || load_wr;
      wa_a <= a_go ? a_rd   : (load_wr ? load_rd   : '0);
      wd_a <= a_go ? a_data : (load_wr ? load_data : '0);
      we_b <= b_go || (load_wr && a_go);
      wa_b <= b_go ? b_rd   : ((load_wr && a_go) ? load_rd   : '0);
      wd_b <= b_go ? b_data : ((load_wr && a_go) ? load_data : '0);

      for (int i = 0; i < LQ_DEPTH; i++) begin
        if ((a_go && (lq_rd[i] == a_rd)) || (b_go && (lq_rd[i] == b_rd)))
          lq_dead[i] <= 1'b1;
      end
      if (pop) head <= head + PW'(1);
      if (push) begin
        lq_dead[tail] <= 1'b0;
        tail          <= tail + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model predicts port writes, ld_ready,
// busy and lq_count; a monitor checks registered writes and rebuilds the register file.
module tb_regfile_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LQ_DEPTH = 4;
  localparam int NR = 2**AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0, ld_valid = 1'b0;
  logic [AW-1:0] a_rd = '0, b_rd = '0, ld_rd = '0;
  logic [DW-1:0] a_data = '0, b_data = '0, ld_data = '0;
  logic ld_ready, we_a, we_b;
  logic [AW-1:0] wa_a, wa_b;
  logic [DW-1:0] wd_a, wd_b;
  logic [NR-1:0] busy;
  logic [$clog2(LQ_DEPTH):0] lq_count;

  regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .busy(busy), .lq_count(lq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    bit            dead;
  } ent_t;

  // Expected write word: {we_a, wa_a, wd_a, we_b, wa_b, wd_b}
  localparam int EW = 2 * (1 + AW + DW);
  logic [EW-1:0] exp_q[$];
  ent_t          lq[$];
  logic [DW-1:0] arch_rf  [NR];
  logic [DW-1:0] model_rf [NR];
  logic [DW-1:0] dut_rf   [NR];
  int checks = 0;
  int errors = 0;
  bit last_acc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model decides what the arbiter must write on the next cycle.
  task automatic drive_cycle(input logic r,
                             input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                             input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                             input logic lv, input logic [AW-1:0] lr, input logic [DW-1:0] ldd);
    logic ae, be, slot, rdy, acc, kill, byp, lw, was_empty;
    logic [AW-1:0] lw_rd;
    logic [DW-1:0] lw_d;
    logic [NR-1:0] eb;
    logic wea, web;
    logic [AW-1:0] waa, wab;
    logic [DW-1:0] wda, wdb;
    ent_t h;
    @(negedge clk);
    rst_n = r; a_valid = av; a_rd = ar; a_data = ad;
    b_valid = bv; b_rd = br; b_data = bd;
    ld_valid = lv; ld_rd = lr; ld_data = ldd;
    #1;
    if (!r) begin
      check("ld_ready_in_reset", 64'(ld_ready), 64'd0);
      lq.delete();
      for (int i = 0; i < NR; i++) arch_rf[i] = model_rf[i];
      exp_q.push_back('0);
      last_acc = 0;
      return;
    end
    ae = av && (ar != 0) && !(bv && br == ar);
    be = bv && (br != 0);
    slot = !ae || !be;
    eb = '0;
    foreach (lq[i]) if (!lq[i].dead) eb[lq[i].rd] = 1'b1;
    rdy = (lq.size() < LQ_DEPTH) || (lq.size() > 0 && slot);
    check("ld_ready", 64'(ld_ready), 64'(rdy));
    check("lq_count", 64'(lq_count), 64'(lq.size()));
    check("busy", 64'(busy), 64'(eb));

    acc = lv && rdy;
    kill = (lr == 0) || (ae && lr == ar) || (be && lr == br);
    was_empty = (lq.size() == 0);
    byp = 0; lw = 0; lw_rd = '0; lw_d = '0;
    if (slot && !was_empty) begin
      h = lq.pop_front();
      if (!h.dead && !(ae && h.rd == ar) && !(be && h.rd == br)) begin
        lw = 1; lw_rd = h.rd; lw_d = h.data;
      end
    end else if (slot && acc && !kill) begin
      byp = 1; lw = 1; lw_rd = lr; lw_d = ldd;
    end
    foreach (lq[i]) if ((ae && lq[i].rd == ar) || (be && lq[i].rd == br)) lq[i].dead = 1;
    if (acc && !kill && !byp) lq.push_back('{lr, ldd, 1'b0});

    // Program order within a cycle: incoming load, then lane A, then lane B.
    if (acc && lr != 0) arch_rf[lr] = ldd;
    if (ae) arch_rf[ar] = ad;
    if (be) arch_rf[br] = bd;

    wea = 0; waa = '0; wda = '0; web = 0; wab = '0; wdb = '0;
    if (ae) begin wea = 1; waa = ar; wda = ad; end
    else if (lw) begin wea = 1; waa = lw_rd; wda = lw_d; end
    if (be) begin web = 1; wab = br; wdb = bd; end
    else if (lw && ae) begin web = 1; wab = lw_rd; wdb = lw_d; end
    if (wea) model_rf[waa] = wda;
    if (web) model_rf[wab] = wdb;
    exp_q.push_back({wea, waa, wda, web, wab, wdb});
    last_acc = acc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1, 0, '0, '0, 0, '0, '0, 0, '0, '0);
  endtask

  // Monitor: registered write ports are compared one cycle after their stimulus.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("we_a", 64'(we_a), 64'(e[75]));
        if (e[75]) check("port_a", 64'({wa_a, wd_a}), 64'(e[74:38]));
        check("we_b", 64'(we_b), 64'(e[37]));
        if (e[37]) check("port_b", 64'({wa_b, wd_b}), 64'(e[36:0]));
        if (we_a && we_b) check("port_clash", 64'(wa_a == wa_b), 64'd0);
        if (we_a) dut_rf[wa_a] = wd_a;
        if (we_b) dut_rf[wa_b] = wd_b;
      end
    end
  end

  initial begin
    int k;
    logic cv;
    logic [AW-1:0] cr;
    logic [DW-1:0] cd;
    logic av, bv;
    for (int i = 0; i < NR; i++) begin
      arch_rf[i] = '0; model_rf[i] = '0; dut_rf[i] = '0;
    end

    drive_cycle(0, 0, '0, '0, 0, '0, '0, 0, '0, '0);
    drive_cycle(0, 0, '0, '0, 0, '0, '0, 0, '0, '0);

    // ALU only, then intra-cycle WAW on x7
    drive_cycle(1, 1, 5'd5, 32'h11, 1, 5'd6, 32'h22, 0, '0, '0);
    drive_cycle(1, 1, 5'd7, 32'h33, 1, 5'd7, 32'h44, 0, '0, '0);

    // Load bypass next to lane A, then alone on port A
    drive_cycle(1, 1, 5'd3, 32'h55, 0, '0, '0, 1, 5'd9, 32'hDEAD);
    drive_cycle(1, 0, '0, '0, 0, '0, '0, 1, 5'd10, 32'hBEEF);

    // Backpressure: both lanes busy, five loads offered; then lane B drops and the FIFO drains
    k = 0;
    for (int i = 0; i < 14; i++) begin
      drive_cycle(1, 1, 5'(16 + i % 8), 32'(i), (i < 6), 5'(24 + i % 8), 32'(i + 50),
                  (k < 5), 5'(1 + k), 32'(k + 100));
      if (last_acc) k++;
    end
    idle(3);

    // WAW kill: load x12 waits, lane A overwrites x12; then load x13 dies against lane B
    drive_cycle(1, 1, 5'd16, 32'h1, 1, 5'd17, 32'h2, 1, 5'd12, 32'hAAAA);
    drive_cycle(1, 1, 5'd12, 32'h5, 1, 5'd18, 32'h3, 0, '0, '0);
    drive_cycle(1, 0, '0, '0, 1, 5'd13, 32'h77, 1, 5'd13, 32'h66);
    idle(3);

    // Reset mid-operation with three loads queued
    for (int i = 0; i < 3; i++)
      drive_cycle(1, 1, 5'(20 + i), 32'(i), 1, 5'(24 + i), 32'(i), 1, 5'(3 + i), 32'(i + 900));
    drive_cycle(0, 0, '0, '0, 0, '0, '0, 0, '0, '0);
    idle(4);

    // rd=0 filtering
    drive_cycle(1, 1, 5'd0, 32'h9, 0, '0, '0, 1, 5'd0, 32'h55);
    drive_cycle(1, 1, 5'd0, 32'h9, 1, 5'd0, 32'h8, 1, 5'd0, 32'h56);
    idle(2);

    // Random traffic with small rd range for collisions; unaccepted loads are held.
    cv = 0; cr = '0; cd = '0;
    for (int i = 0; i < 800; i++) begin
      if (last_acc || !cv) begin
        cv = ($urandom_range(0, 2) != 0);
        cr = 5'($urandom_range(0, 7));
        cd = $urandom;
      end
      if ((i / 50) % 2 == 0) begin
        av = ($urandom_range(0, 9) < 9);
        bv = ($urandom_range(0, 9) < 8);
      end else begin
        av = ($urandom_range(0, 3) == 0);
        bv = ($urandom_range(0, 3) == 0);
      end
      drive_cycle(1, av, 5'($urandom_range(0, 7)), $urandom,
                  bv, 5'($urandom_range(0, 7)), $urandom, cv, cr, cd);
    end
    idle(8);
    @(negedge clk);
    @(negedge clk);

    for (int r = 1; r < NR; r++) check($sformatf("rf_x%0d", r), 64'(dut_rf[r]), 64'(arch_rf[r]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Writeback arbiter for the dual-write-port register file. It shares the two write ports (A, B) among three producers: ALU lane A, ALU lane B and the load unit. ALU lanes never stall. Load results are buffered in a small FIFO when no port is free, and the arbiter enforces write-after-write ordering. It also exports a per-register busy mask so issue logic can stall on pending load writes.

Parameters:
ADDR_WIDTH, 5, register address width
DATA_WIDTH, 32, register data width
LQ_DEPTH, 4, load writeback FIFO depth (power of 2, >= 2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
a_valid  in  1  lane A result valid
a_rd  in  ADDR_WIDTH  lane A destination
a_data  in  DATA_WIDTH  lane A result
b_valid  in  1  lane B result valid (B is younger than A)
b_rd  in  ADDR_WIDTH  lane B destination
b_data  in  DATA_WIDTH  lane B result
ld_valid  in  1  load result valid
ld_rd  in  ADDR_WIDTH  load destination
ld_data  in  DATA_WIDTH  load data
ld_ready  out  1  load result accepted when ld_valid & ld_ready
we_a  out  1  regfile port A write enable
wa_a  out  ADDR_WIDTH  port A write address
wd_a  out  DATA_WIDTH  port A write data
we_b  out  1  regfile port B write enable
wa_b  out  ADDR_WIDTH  port B write address
wd_b  out  DATA_WIDTH  port B write data
busy  out  2**ADDR_WIDTH  bit r set while a live FIFO entry targets r
lq_count  out  $clog2(LQ_DEPTH)+1  live+dead entries in FIFO

Behaviour:
- Reset (rst_n=0 at posedge): FIFO emptied. All we_*/wa_*/wd_* = 0. busy = 0. lq_count = 0. ld_ready is forced 0 while rst_n=0.
- Write-port outputs are registered. Inputs sampled at edge N appear on the ports during cycle N+1. One cycle of latency for ALU and bypassed loads.
- Filtering: any request with rd=0 is dropped and uses no port. An accepted load with rd=0 is consumed, not enqueued.
- Intra-cycle WAW: if a_valid & b_valid & a_rd==b_rd, lane A is suppressed.
- Load vs ALU in the same cycle: an incoming load is older than same-cycle ALU results. If ld_rd matches a valid a_rd or b_rd, the load is accepted and dropped.
- FIFO vs ALU: a valid ALU rd matching a FIFO entry's rd marks that entry dead (killed). It stays in the FIFO, is excluded from busy, and is popped without using a port.
- Port allocation per cycle:
  - lane A gets port A; lane B gets port B.
  - At most one load write per cycle, on a free port, preferring port A.
  - Load source priority: FIFO head first. Bypass of the incoming load only when the FIFO is empty.
  - Otherwise the incoming load is enqueued.
  - A dead head pops in one cycle, consumes the load slot and drives no write.
- Same-cycle pop and push is allowed, and count is unchanged.
- ld_ready = (lq_count < LQ_DEPTH) | head_pops_this_cycle. Combinational from state plus a_valid/b_valid.
- The arbiter never asserts we_a and we_b with wa_a == wa_b.
- FIFO pointers wrap modulo LQ_DEPTH. Loads sharing an rd drain in arrival order.
- busy is combinational from FIFO state. Bit 0 is always 0.

Test Plan:
- Reset mid-operation: fill FIFO with 3 loads, pulse rst_n low 1 cycle -> lq_count=0, busy=0, we_a=we_b=0 next cycle, no stale entry written later.
- ALU-only: a=(x5,0x11), b=(x6,0x22) -> next cycle we_a=1 wa_a=5 wd_a=0x11, we_b=1 wa_b=6 wd_b=0x22. Then a_rd=b_rd=7 -> only we_b=1, wa_b=7.
- Load bypass: a_valid only, ld=(x9,0xDEAD), FIFO empty -> next cycle we_a=1 (ALU), we_b=1 wa_b=9 wd_b=0xDEAD. With no ALU traffic the load goes on port A.
- Backpressure: a_valid=b_valid=1 every cycle with distinct rds, 5 loads offered -> 4 enqueued, ld_ready=0 on 5th, busy shows 4 rds. Drop b_valid -> one load drains per cycle on port B in order, ld_ready reasserts.
- WAW kill: FIFO holds load x12. Lane A writes x12=0x5 -> busy[12]=0, dead entry pops with no write, final x12=0x5. Same-cycle ld_rd=13 and b_rd=13 -> only lane B write observed.
- rd=0 filtering: a_rd=0, ld_rd=0 with valids high -> we_a=0, no FIFO growth, ld_ready stays 1.
